// File: rtl/led_bus_arbiter.sv
// led_bus_arbiter: round-robin owner of the 8-bit LED/header bus with a minimum per-grant dwell.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   req_i   per-requester bus request, level-sensitive
//   data_i  requester i pattern at data_i[i*BITS +: BITS]
//   gnt_o   registered one-hot grant, zero while the bus is free
//   out_o   registered bus value for the pins
//   busy_o  high while a grant is held
//   tick_o  one-cycle prescaler strobe shared with the pattern sources
module led_bus_arbiter #(
    parameter int BITS  = 8,
    parameter int NREQ  = 4,
    parameter int DIV   = 22,
    parameter int DWELL = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*BITS-1:0] data_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [BITS-1:0]      out_o,
    output logic                 busy_o,
    output logic                 tick_o
);
    localparam int IW  = $clog2(NREQ);
    localparam int IW1 = IW + 1;
    localparam logic [7:0] DW = 8'(DWELL);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t          state_q, state_d;
    logic [DIV-1:0]  cnt_q;
    logic            tick_q;
    logic [7:0]      dwell_q, dwell_d;
    logic [IW-1:0]   rr_q, rr_d, win;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [BITS-1:0] out_q, out_d;
    logic [IW1-1:0]  idx;
    logic            found, expired, owner_drop, others;
    // Search order starts just after the last owner and wraps modulo NREQ,
    // so the previous owner is considered last.
    always_comb begin
        win   = rr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = {1'b0, rr_q} + IW1'(k);
            if (idx >= IW1'(NREQ)) idx = idx - IW1'(NREQ);
            if (!found && req_i[idx[IW-1:0]]) begin
                win   = idx[IW-1:0];
                found = 1'b1;
            end
        end
    end
    // While granted, rr_q is the owner index.
    assign owner_drop = !req_i[rr_q];
    assign expired    = dwell_q == DW;
    assign others     = |(req_i & ~gnt_q);
    always_comb begin
        state_d = (state_q == GRANT) ? ((owner_drop || (expired && others)) ? GAP : GRANT)
                                     : (found ? GRANT : IDLE);
    end
    always_comb begin
        gnt_d   = '0;
        rr_d    = rr_q;
        dwell_d = '0;
        out_d   = '0;
        busy_o  = state_q == GRANT;
        if (state_q != GRANT && found) begin
            gnt_d[win] = 1'b1;
            rr_d       = win;
        end
        // Dwell below DWELL can only climb to DWELL, so saturation falls out;
        // an uncontested expiry restarts the count while keeping the grant.
        if (state_q == GRANT && state_d == GRANT) begin
            gnt_d   = gnt_q;
            out_d   = data_i[int'(rr_q)*BITS +: BITS];
            dwell_d = expired ? 8'd0 : dwell_q + {7'd0, tick_q};
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            dwell_q <= '0;
            rr_q    <= IW'(NREQ - 1);
            gnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + 1'b1;
            tick_q  <= &cnt_q;
            dwell_q <= dwell_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            out_q   <= out_d;
        end
    end
    assign gnt_o  = gnt_q;
    assign out_o  = out_q;
    assign tick_o = tick_q;
endmodule
